memory_arbiter: RTL and testbench

Shares one single-port, 1-cycle-latency program memory between the processor's instruction-fetch port and a host loader/debug port. The processor always wins arbitration so its fixed fetch timing is never disturbed. The host can also freeze the processor: the block drains in-flight fetches, then holds the processor in reset for exclusive memory access. The block sits between the processor, the host bridge and the memory macro.

---
 rtl/memory_arbiter.sv | 128 ++++++++++++
 tb/tb_memory_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Arbitrates one single-port program memory between CPU fetch and host port.
// The CPU always wins; the host can drain and freeze the CPU in reset.
module memory_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic [31:0]           cpu_address,
    input  logic                  cpu_read_strobe,
    output logic [31:0]           cpu_read_data,
    output logic                  cpu_reset,
    input  logic                  host_valid,
    input  logic                  host_write,
    input  logic [ADDR_WIDTH-1:0] host_address,
    input  logic [31:0]           host_write_data,
    output logic                  host_ready,
    output logic [31:0]           host_read_data,
    output logic                  host_read_valid,
    input  logic                  host_hold,
    output logic                  host_held,
    output logic [15:0]           stall_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    localparam int CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HELD,
        RELEASE
    } hold_state_t;

    hold_state_t      state;
    hold_state_t      state_next;
    logic [CNT_W-1:0] rel_cnt;
    logic [CNT_W-1:0] rel_cnt_next;

    logic cpu_grant;
    logic host_grant;
    logic cpu_pending;
    logic host_pending;

    // Only the low address bits index the memory; the rest wrap.
    logic addr_unused;
    assign addr_unused = ^cpu_address[31:ADDR_WIDTH];

    always_comb begin
        cpu_grant  = cpu_read_strobe && (state != HELD);
        host_grant = host_valid && !cpu_grant;
    end

    assign host_ready       = host_grant;
    assign mem_address      = cpu_grant ? cpu_address[ADDR_WIDTH-1:0]
                                        : host_address;
    assign mem_read_enable  = cpu_grant || (host_grant && !host_write);
    assign mem_write_enable = host_grant && host_write;
    assign mem_write_data   = host_write_data;
    assign cpu_read_data    = mem_read_data;

    assign cpu_reset = (state == HELD) || (state == RELEASE);
    assign host_held = (state == HELD);

    always_comb begin
        state_next   = state;
        rel_cnt_next = rel_cnt;
        unique case (state)
            RUN: begin
                if (host_hold) state_next = DRAIN;
            end
            DRAIN: begin
                if (!host_hold)
                    state_next = RUN;
                else if (!cpu_pending && !cpu_read_strobe)
                    state_next = HELD;
            end
            HELD: begin
                if (!host_hold) begin
                    state_next   = RELEASE;
                    rel_cnt_next = CNT_LOAD;
                end
            end
            RELEASE: begin
                if (rel_cnt == '0)
                    state_next = RUN;
                else
                    rel_cnt_next = rel_cnt - CNT_W'(1);
            end
            default: state_next = RUN;
        endcase
    end

    // Reset lands in RELEASE so the CPU leaves reset a fixed time later.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state   <= RELEASE;
            rel_cnt <= CNT_LOAD;
        end else begin
            state   <= state_next;
            rel_cnt <= rel_cnt_next;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            cpu_pending     <= 1'b0;
            host_pending    <= 1'b0;
            host_read_data  <= '0;
            host_read_valid <= 1'b0;
            stall_count     <= '0;
        end else begin
            cpu_pending     <= cpu_grant;
            host_pending    <= host_grant && !host_write;
            host_read_valid <= host_pending;
            if (host_pending)
                host_read_data <= mem_read_data;
            if (host_valid && !host_grant && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: memory macro model, cycle reference model,
// vector table, directed hold/reset/collision sequences and random traffic.
module tb_memory_arbiter;

    localparam int AW = 8;
    localparam int RC = 2;

    logic          CLK = 1'b0;
    logic          resetn;
    logic [31:0]   cpu_address;
    logic          cpu_read_strobe;
    logic [31:0]   cpu_read_data;
    logic          cpu_reset;
    logic          host_valid;
    logic          host_write;
    logic [AW-1:0] host_address;
    logic [31:0]   host_write_data;
    logic          host_ready;
    logic [31:0]   host_read_data;
    logic          host_read_valid;
    logic          host_hold;
    logic          host_held;
    logic [15:0]   stall_count;
    logic [AW-1:0] mem_address;
    logic          mem_read_enable;
    logic          mem_write_enable;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data;

    always #5 CLK = ~CLK;

    memory_arbiter #(.ADDR_WIDTH(AW), .RELEASE_CYCLES(RC)) dut (
        .CLK(CLK), .resetn(resetn),
        .cpu_address(cpu_address), .cpu_read_strobe(cpu_read_strobe),
        .cpu_read_data(cpu_read_data), .cpu_reset(cpu_reset),
        .host_valid(host_valid), .host_write(host_write),
        .host_address(host_address), .host_write_data(host_write_data),
        .host_ready(host_ready), .host_read_data(host_read_data),
        .host_read_valid(host_read_valid), .host_hold(host_hold),
        .host_held(host_held), .stall_count(stall_count),
        .mem_address(mem_address), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    // Single-port memory macro with one cycle read latency.
    logic [31:0] mem [256];
    always @(posedge CLK) begin
        if (mem_write_enable) mem[mem_address] <= mem_write_data;
        if (mem_read_enable) mem_read_data <= mem[mem_address];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h, want %h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // Reference model state, expressed in terms of observable behaviour.
    typedef struct {
        int          due;
        logic [31:0] d;
    } rd_t;

    logic [31:0] ref_mem [256];
    bit          m_frozen;
    bit          m_drain;
    int          m_rel;
    int          m_stall;
    int          m_cyc = 0;
    bit          m_cpu_prev;
    logic [31:0] m_cpu_data;
    logic [31:0] m_last;
    rd_t         m_q[$];

    task automatic model_reset();
        m_frozen   = 0;
        m_drain    = 0;
        m_rel      = RC;
        m_stall    = 0;
        m_cpu_prev = 0;
        m_last     = '0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit cw;
        bit hw;
        bit exp_v;
        cw = cpu_read_strobe && !m_frozen;
        hw = host_valid && !cw;
        chk("host_ready", host_ready, hw);
        chk("mem_re", mem_read_enable, cw || (hw && !host_write));
        chk("mem_we", mem_write_enable, hw && host_write);
        if (cw) chk("mem_addr_cpu", mem_address, cpu_address[AW-1:0]);
        else if (hw) chk("mem_addr_host", mem_address, host_address);
        if (hw && host_write) chk("mem_wdata", mem_write_data, host_write_data);
        chk("cpu_reset", cpu_reset, m_frozen || (m_rel > 0));
        chk("host_held", host_held, m_frozen);
        chk("stall_count", stall_count, m_stall);
        exp_v = 0;
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
            exp_v  = 1;
            m_last = m_q[0].d;
            void'(m_q.pop_front());
        end
        chk("host_rvalid", host_read_valid, exp_v);
        chk("host_rdata", host_read_data, m_last);
        if (m_cpu_prev) chk("cpu_rdata", cpu_read_data, m_cpu_data);
        if (host_valid && !hw && m_stall < 65535) m_stall++;
        if (hw && !host_write) m_q.push_back('{m_cyc + 2, ref_mem[host_address]});
        if (hw && host_write) ref_mem[host_address] = host_write_data;
        if (m_frozen) begin
            if (!host_hold) begin
                m_frozen = 0;
                m_rel    = RC;
            end
        end else if (m_rel > 0) begin
            m_rel--;
        end else if (m_drain) begin
            if (!host_hold) m_drain = 0;
            else if (!m_cpu_prev && !cpu_read_strobe) begin
                m_drain  = 0;
                m_frozen = 1;
            end
        end else if (host_hold) begin
            m_drain = 1;
        end
        m_cpu_prev = cw;
        if (cw) m_cpu_data = ref_mem[cpu_address[AW-1:0]];
        m_cyc++;
    endtask

    task automatic sample();
        @(negedge CLK);
        if (resetn) model_step();
    endtask

    task automatic advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        cpu_read_strobe = 0;
        cpu_address     = '0;
        host_valid      = 0;
        host_write      = 0;
        host_address    = '0;
        host_write_data = '0;
        host_hold       = 0;
    endtask

    task automatic reset_pulse();
        resetn = 0;
        model_reset();
        idle_inputs();
        sample();
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_rvalid", host_read_valid, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_held", host_held, 0);
        advance();
        resetn = 1;
    endtask

    typedef struct {
        logic          strobe;
        logic [31:0]   caddr;
        logic          hv;
        logic          hw;
        logic [AW-1:0] haddr;
        logic [31:0]   hwd;
        logic          e_ready;
        logic          e_re;
        logic          e_we;
        logic          e_chk_addr;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vec [9];

    initial begin
        bit stalled;
        bit seen;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        vec[0] = '{1, 32'h0000_0103, 0, 0, 8'h00, 32'h0, 0, 1, 0, 1, 8'h03};
        vec[1] = '{1, 32'hFFFF_FF20, 1, 1, 8'h40, 32'hDEADBEEF, 0, 1, 0, 1, 8'h20};
        vec[2] = '{0, 32'h0, 1, 1, 8'h40, 32'hDEADBEEF, 1, 0, 1, 1, 8'h40};
        vec[3] = '{0, 32'h0, 1, 0, 8'h40, 32'h0, 1, 1, 0, 1, 8'h40};
        vec[4] = '{0, 32'h0, 1, 0, 8'h41, 32'h0, 1, 1, 0, 1, 8'h41};
        vec[5] = '{0, 32'h0, 0, 0, 8'h41, 32'h0, 0, 0, 0, 0, 8'h00};
        vec[6] = '{1, 32'h0000_007F, 0, 1, 8'h41, 32'h0, 0, 1, 0, 1, 8'h7F};
        vec[7] = '{0, 32'h0, 1, 1, 8'h41, 32'h12345678, 1, 0, 1, 1, 8'h41};
        vec[8] = '{0, 32'h0, 1, 0, 8'h41, 32'h0, 1, 1, 0, 1, 8'h41};

        // Reset release timing.
        resetn = 0;
        model_reset();
        idle_inputs();
        #2;
        advance();
        reset_pulse();
        for (int k = 0; k < RC + 2; k++) begin
            sample();
            chk("rel_cpu_reset", cpu_reset, (k < RC));
            advance();
        end

        // Preload every memory word through the host port.
        for (int i = 0; i < 256; i++) begin
            host_valid      = 1;
            host_write      = 1;
            host_address    = AW'(i);
            host_write_data = $urandom;
            cyc();
        end
        idle_inputs();

        // Collision right after a fresh reset.
        reset_pulse();
        repeat (RC + 1) cyc();
        cpu_read_strobe = 1;
        cpu_address     = 32'h10;
        host_valid      = 1;
        host_address    = 8'h05;
        sample();
        chk("col_ready", host_ready, 0);
        chk("col_addr", mem_address, 8'h10);
        advance();
        cpu_read_strobe = 0;
        sample();
        chk("col_stall", stall_count, 1);
        chk("col_accept", host_ready, 1);
        advance();
        host_valid = 0;
        sample();
        chk("col_rv_early", host_read_valid, 0);
        advance();
        sample();
        chk("col_rv", host_read_valid, 1);
        chk("col_rdata", host_read_data, ref_mem[5]);
        advance();
        sample();
        chk("col_rv_pulse", host_read_valid, 0);
        advance();

        // Combinational grant vectors.
        for (int i = 0; i < 9; i++) begin
            cpu_read_strobe = vec[i].strobe;
            cpu_address     = vec[i].caddr;
            host_valid      = vec[i].hv;
            host_write      = vec[i].hw;
            host_address    = vec[i].haddr;
            host_write_data = vec[i].hwd;
            sample();
            chk($sformatf("vec%0d_ready", i), host_ready, vec[i].e_ready);
            chk($sformatf("vec%0d_re", i), mem_read_enable, vec[i].e_re);
            chk($sformatf("vec%0d_we", i), mem_write_enable, vec[i].e_we);
            if (vec[i].e_chk_addr)
                chk($sformatf("vec%0d_addr", i), mem_address, vec[i].e_addr);
            advance();
        end
        idle_inputs();
        repeat (3) cyc();

        // Hold abort while a fetch is pending.
        cpu_read_strobe = 1;
        cpu_address     = 32'h22;
        cyc();
        cpu_read_strobe = 0;
        host_hold       = 1;
        cyc();
        host_hold = 0;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("abort_cpu_reset", cpu_reset, 0);
            chk("abort_held", host_held, 0);
            advance();
        end

        // Hold, load a program, read it back, release.
        cpu_read_strobe = 1;
        cpu_address     = 32'h10;
        host_hold       = 1;
        sample();
        chk("hold_not_yet", host_held, 0);
        advance();
        cpu_read_strobe = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            sample();
            if (host_held) seen = 1;
            else advance();
        end
        chk("held_rise", seen, 1);
        if (seen) advance();
        cpu_read_strobe = 1;
        cpu_address     = 32'h33;
        host_valid      = 1;
        host_write      = 1;
        host_address    = 8'h00;
        host_write_data = 32'h00500093;
        sample();
        chk("held_wr0_ready", host_ready, 1);
        advance();
        host_address    = 8'h01;
        host_write_data = 32'h00508093;
        sample();
        chk("held_wr1_ready", host_ready, 1);
        advance();
        host_write   = 0;
        host_address = 8'h00;
        cyc();
        host_valid      = 0;
        cpu_read_strobe = 0;
        cyc();
        sample();
        chk("held_rb_valid", host_read_valid, 1);
        chk("held_rb_data", host_read_data, 32'h00500093);
        advance();
        host_hold = 0;
        sample();
        chk("unhold_cpu_reset", cpu_reset, 1);
        advance();
        for (int k = 0; k < RC + 1; k++) begin
            sample();
            chk("unhold_rel", cpu_reset, (k < RC));
            advance();
        end
        cpu_read_strobe = 1;
        cpu_address     = 32'h0;
        sample();
        chk("boot_addr", mem_address, 8'h00);
        advance();
        cpu_read_strobe = 0;
        sample();
        chk("boot_fetch", cpu_read_data, 32'h00500093);
        advance();

        // Reset in the middle of a host read discards it.
        host_valid   = 1;
        host_address = 8'h41;
        cyc();
        reset_pulse();
        for (int k = 0; k < RC + 3; k++) begin
            sample();
            chk("rst_mid_rv", host_read_valid, 0);
            advance();
        end

        // Random traffic against the reference model.
        stalled = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(39) == 0) host_hold = !host_hold;
            cpu_read_strobe = ($urandom_range(2) == 0);
            cpu_address     = $urandom;
            if (!stalled) begin
                host_valid      = $urandom_range(1);
                host_write      = $urandom_range(1);
                host_address    = AW'($urandom);
                host_write_data = $urandom;
            end
            sample();
            stalled = host_valid && !host_ready;
            advance();
        end
        idle_inputs();
        repeat (RC + 4) cyc();

        // Stall counter saturation.
        cpu_read_strobe = 1;
        cpu_address     = 32'h7;
        host_valid      = 1;
        host_address    = 8'h09;
        repeat (66000) cyc();
        sample();
        chk("stall_sat", stall_count, 16'hFFFF);
        advance();
        sample();
        chk("stall_sat_hold", stall_count, 16'hFFFF);
        advance();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
